// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with exact occupancy count.
// It provides programmable almost-full/almost-empty flags, sticky
// overflow/underflow errors and a synchronous flush (clr).
// Optional feature macro: SYNC_FIFO_FWFT_EN selects first-word-fall-through.
// With it, data_out shows the head entry combinationally.
// Without it, data_out is registered with one cycle of read latency.
module sync_fifo_flags #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         w_en,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         r_en,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // Elaboration-time parameter legality checks
  if (DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_flags: DEPTH must be >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo_flags: AF_THRESH must be in 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_flags: AE_THRESH must be in 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] w_ptr_q, w_ptr_d;
  logic [PW-1:0] r_ptr_q, r_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          wr_acc;
  logic          rd_acc;

  // Status flags decode the registered count, never the pointers
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AF_THRESH));
  assign almost_empty = (count_q <= CW'(AE_THRESH));
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign wr_acc = w_en & ~full;
  assign rd_acc = r_en & ~empty;

  // Next-state: explicit pointer wrap so non-power-of-two depths work
  always_comb begin
    w_ptr_d     = w_ptr_q;
    r_ptr_d     = r_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q | (w_en & full);
    underflow_d = underflow_q | (r_en & empty);
    if (wr_acc) begin
      w_ptr_d = (w_ptr_q == PW'(DEPTH - 1)) ? '0 : w_ptr_q + PW'(1);
    end
    if (rd_acc) begin
      r_ptr_d = (r_ptr_q == PW'(DEPTH - 1)) ? '0 : r_ptr_q + PW'(1);
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state: async reset, clr flushes and drops same-cycle requests
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (clr) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_acc && !clr) begin
      mem[w_ptr_q] <= data_in;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head entry falls through; an empty FIFO presents zero
  always_comb begin
    data_out = '0;
    if (!empty) begin
      data_out = mem[r_ptr_q];
    end
  end
`else
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

  // Read word is captured on the accepting edge, otherwise held
  always_comb begin
    data_out_d = data_out_q;
    if (rd_acc) begin
      data_out_d = mem[r_ptr_q];
    end
  end

  // Registered read port, zeroed by reset and by clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
    end else if (clr) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Testbench for sync_fifo_flags: scoreboard queues hold the expected read
// words, and monitors pop and compare them when read data is due.
// Status flags are compared directly after each clock edge.
module tb_sync_fifo_flags;

`ifdef SYNC_FIFO_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr, w_en, r_en;
  logic [7:0] data_in, data_out;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  logic       clr10, w10, r10;
  logic [7:0] d10, q10;
  logic       full10, empty10, af10, ae10, of10, uf10;
  logic [3:0] count10;

  logic       rd_exp, rd_exp10;
  logic [7:0] exp_q[$];
  logic [7:0] exp_q10[$];
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  sync_fifo_flags #(.DEPTH(16), .DATA_WIDTH(8), .AF_THRESH(12), .AE_THRESH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .w_en(w_en), .data_in(data_in),
    .r_en(r_en), .data_out(data_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_flags #(.DEPTH(10), .DATA_WIDTH(8), .AF_THRESH(8), .AE_THRESH(2)) u_dut10 (
    .clk(clk), .rst_n(rst_n), .clr(clr10), .w_en(w10), .data_in(d10),
    .r_en(r10), .data_out(q10), .full(full10), .empty(empty10),
    .almost_full(af10), .almost_empty(ae10), .count(count10),
    .overflow(of10), .underflow(uf10)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; sel picks the DUT, rdx marks an expected read word
  task automatic step(input bit sel, input bit w, input logic [7:0] d, input bit r,
                      input bit c, input bit rdx, input logic [7:0] ed);
    w_en = 0; r_en = 0; clr = 0; rd_exp = 0;
    w10 = 0; r10 = 0; rd_exp10 = 0;
    if (!sel) begin
      w_en = w; data_in = d; r_en = r; clr = c; rd_exp = rdx;
      if (rdx) exp_q.push_back(ed);
    end else begin
      w10 = w; d10 = d; r10 = r; rd_exp10 = rdx;
      if (rdx) exp_q10.push_back(ed);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic mon_pop(input bit which);
    logic [7:0] e;
    if (!which) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb16_underrun actual=read expected=no_read");
      end else begin
        e = exp_q.pop_front();
        chk("sb16_data", data_out, e);
        $display("rd16 data=%02h exp=%02h", data_out, e);
      end
    end else begin
      if (exp_q10.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb10_underrun actual=read expected=no_read");
      end else begin
        e = exp_q10.pop_front();
        chk("sb10_data", q10, e);
        $display("rd10 data=%02h exp=%02h", q10, e);
      end
    end
  endtask

  // Monitors: registered mode checks after the accepting edge, FWFT before it
  initial begin
    bit fire;
    forever begin
      @(posedge clk);
      fire = rd_exp;
      @(negedge clk);
      if (FWFT) fire = rd_exp;
      if (fire) mon_pop(1'b0);
    end
  end

  initial begin
    bit fire;
    forever begin
      @(posedge clk);
      fire = rd_exp10;
      @(negedge clk);
      if (FWFT) fire = rd_exp10;
      if (fire) mon_pop(1'b1);
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_ae"}, almost_empty, 1);
    chk({tag, "_af"}, almost_full, 0);
    chk({tag, "_of"}, overflow, 0);
    chk({tag, "_uf"}, underflow, 0);
    chk({tag, "_dout"}, data_out, 0);
  endtask

  initial begin
    rst_n = 0; clr = 0; w_en = 0; r_en = 0; data_in = 0; rd_exp = 0;
    clr10 = 0; w10 = 0; r10 = 0; d10 = 0; rd_exp10 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("rst");
    chk("rst_count10", count10, 0);
    rst_n = 1;

    // Fill 0xA0..0xAF
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 8'(8'hA0 + i), 0, 0, 0, 0);
      chk("fill_count", count, i + 1);
      chk("fill_af", almost_full, (i + 1 >= 12));
      chk("fill_ae", almost_empty, (i + 1 <= 4));
    end
    chk("fill_full", full, 1);
    chk("fill_of", overflow, 0);
    $display("fill done count=%0d full=%0b", count, full);

    // Write while full is rejected and sets overflow
    step(0, 1, 8'hFF, 0, 0, 0, 0);
    chk("ovf_count", count, 16);
    chk("ovf_flag", overflow, 1);

    // Drain in order; 0xFF must never appear
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, 1, 0, 1, 8'(8'hA0 + i));
    end
    chk("drain_count", count, 0);
    chk("drain_empty", empty, 1);
    chk("drain_of_sticky", overflow, 1);

    // Read while empty
    step(0, 0, 0, 1, 0, 0, 0);
    chk("udf_flag", underflow, 1);
    chk("udf_count", count, 0);
    chk("udf_dout_hold", data_out, FWFT ? 8'h00 : 8'hAF);

    // Flush
    step(0, 0, 0, 0, 1, 0, 0);
    chk_reset_state("clr");

    // Steady state at count 8 with simultaneous read/write across wrap
    for (int i = 0; i < 8; i++) step(0, 1, 8'(i), 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      step(0, 1, 8'(8 + i), 1, 0, 1, 8'(i));
      chk("rw_count", count, 8);
    end
    chk("rw_of", overflow, 0);
    chk("rw_uf", underflow, 0);

    // Full plus simultaneous read/write: read wins, write dropped
    for (int i = 0; i < 8; i++) step(0, 1, 8'(8'h30 + i), 0, 0, 0, 0);
    chk("full2_count", count, 16);
    step(0, 1, 8'hEE, 1, 0, 1, 8'h28);
    chk("fullrw_count", count, 15);
    chk("fullrw_of", overflow, 1);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 0, 1, 8'(8'h29 + i));
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0, 1, 8'(8'h30 + i));
    chk("fullrw_drain", count, 0);

    // Empty plus simultaneous read/write: write stored, read rejected
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 8'h77, 1, 0, 0, 0);
    chk("emptyrw_count", count, 1);
    chk("emptyrw_uf", underflow, 1);
    step(0, 0, 0, 1, 0, 1, 8'h77);
    chk("emptyrw_drain", count, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset mid-burst at count 7, off the clock edge
    step(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 8'(8'h60 + i), 0, 0, 0, 0);
    chk("burst_count", count, 7);
    w_en = 1; data_in = 8'h99;
    #2 rst_n = 0;
    #1;
    chk_reset_state("arst");
    w_en = 0;
    @(posedge clk);
    #1 rst_n = 1;
    chk("arst_after_count", count, 0);

`ifdef SYNC_FIFO_FWFT_EN
    // Fall-through: head visible without r_en, pop empties to zero
    step(0, 1, 8'h5A, 0, 0, 0, 0);
    chk("fwft_head", data_out, 8'h5A);
    step(0, 0, 0, 1, 0, 0, 0);
    chk("fwft_pop_empty", empty, 1);
    chk("fwft_pop_dout", data_out, 0);
`endif

    // Non-power-of-two depth: steady state at count 5 across several wraps
    for (int i = 0; i < 5; i++) step(1, 1, 8'(8'h40 + i), 0, 0, 0, 0);
    chk("d10_fill_count", count10, 5);
    for (int i = 0; i < 25; i++) begin
      step(1, 1, 8'(8'h45 + i), 1, 0, 1, 8'(8'h40 + i));
      chk("d10_rw_count", count10, 5);
    end
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 0, 1, 8'(8'h59 + i));
    chk("d10_empty", empty10, 1);
    chk("d10_of", of10, 0);
    chk("d10_uf", uf10, 0);

    repeat (3) step(0, 0, 0, 0, 0, 0, 0);
    chk("sb16_left", exp_q.size(), 0);
    chk("sb10_left", exp_q10.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Parametrised successor to the team's basic synchronous FIFO. Single-clock FIFO with arbitrary depth and width and an exact occupancy count. Adds programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush. Sits between producer/consumer stages in the datapath wherever rate decoupling with early back-pressure is needed.

Parameters:
DEPTH, 16, number of entries; any integer >= 2; power of two not required
DATA_WIDTH, 8, word width in bits; full width is stored and returned, no truncation
AF_THRESH, 12, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH
AE_THRESH, 4, almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1

Ports:
clk  input  1  rising-edge clock for all state
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous flush; empties the FIFO in one cycle
w_en  input  1  write request
data_in  input  DATA_WIDTH  write data, sampled when a write is accepted
r_en  input  1  read request
data_out  output  DATA_WIDTH  read data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_THRESH
almost_empty  output  1  count <= AE_THRESH
count  output  $clog2(DEPTH+1)  current occupancy
overflow  output  1  sticky; a write was attempted while full
underflow  output  1  sticky; a read was attempted while empty

Behaviour:
- Reset and clock: one clock, clk; reset is asynchronous and active-low, rst_n.
- While rst_n is low, all state is 0: w_ptr, r_ptr, count, data_out, overflow and underflow. As a result, empty=1, full=0, almost_empty=1 and almost_full=0 (AF_THRESH >= 1). Storage array contents are not reset.
- Pointers: w_ptr and r_ptr are $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0. Wrap is explicit, so non-power-of-2 depths work.
- Flag source: full and empty come from count, not from pointer comparison.
- Write accept: a write is accepted iff w_en && !full. The word is stored at w_ptr and w_ptr advances.
- Read accept: a read is accepted iff r_en && !empty. r_ptr advances.
- count update: +1 on write-only, -1 on read-only, unchanged on both or neither.
- Simultaneous write and read when neither full nor empty: both are accepted and count is unchanged.
- Write and read when full: the read is accepted, the write is rejected and overflow is set. There is no write-through on full.
- Write and read when empty: the write is accepted, the read is rejected and underflow is set. There is no bypass.
- Read latency (default mode): data_out is registered. It updates on the clock edge that accepts the read and is visible in the following cycle. Otherwise it holds its last value.
- Status outputs: full, empty, almost_full, almost_empty and count are combinational decodes of the registered count. They reflect accepted operations in the cycle after the edge.
- Sticky errors: overflow sets on any cycle with w_en && full, and underflow on any cycle with r_en && empty. Each stays set until clr or reset.
- clr: has priority over w_en and r_en in the same cycle. It zeroes pointers, count, data_out, overflow and underflow on that edge. Requests in that cycle are dropped and set no error flags.
- Reset mid-operation: an immediate asynchronous return to the reset state. Stored data is considered lost.
- Parameter checks: AF_THRESH and AE_THRESH outside their legal ranges are a compile-time error, enforced by an elaboration-time check.

Optional Feature:
Macro SYNC_FIFO_FWFT_EN: first-word-fall-through mode.
- Defined: data_out combinationally presents the head entry, fifo[r_ptr], whenever !empty, and 0 when empty. An accepted r_en pops the head, so data_out shows the next word in the same cycle after the edge. Read latency is 0.
- Defined, capacity and flags: capacity, flags, count and error rules are identical to the default mode. clr forces empty, so data_out reads 0.
- Undefined: registered read as described under Behaviour, with 1-cycle latency.

Test Plan:
- Reset then fill (DEPTH=16): write 0xA0..0xAF on 16 consecutive cycles -> count=16, full=1, almost_full=1 from count 12 onward, almost_empty=0 once count reaches 5, overflow=0.
- 17th write of 0xFF while full -> count stays 16, overflow=1 and stays set. Draining gives 0xA0..0xAF in order, 0xFF never appears, and data_out is 1 cycle after each r_en (default mode).
- Read while empty after the drain -> underflow=1, data_out holds 0xAF, count=0. Then clr for 1 cycle -> overflow=0, underflow=0, data_out=0.
- Continuous simultaneous w_en/r_en at count=8 for 40 cycles with incrementing data -> count stays 8, output sequence is continuous across pointer wrap, no error flags. Repeat with DEPTH=10 to check non-power-of-2 wrap.
- Full plus simultaneous read/write -> the read returns the oldest word, the write is dropped, overflow=1, count goes 16->15. Empty plus simultaneous read/write -> the write is stored, underflow=1, count goes 0->1.
- Assert rst_n low asynchronously mid-burst (count=7), off the clock edge -> all outputs return to reset values immediately. With SYNC_FIFO_FWFT_EN, writing 0x5A into an empty FIFO -> data_out=0x5A in the next cycle with no r_en; r_en -> empty=1 and data_out=0.
